// File: rtl/ejector.sv
// ejector: pulls flits addressed to this node off the four inter-router
// channels into a local ejection FIFO and passes everything else through to
// the deflection stage one cycle later.
// Optional feature: define GOLDEN_PRIORITY_EN so that golden matching flits
// win arbitration over non-golden ones.
module ejector #(
    parameter logic [2:0] LOCAL_ROW = 3'b100,
    parameter logic [2:0] LOCAL_COL = 3'b100,
    parameter int         DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] eastad,
    input  logic [9:0] westad,
    input  logic [9:0] northad,
    input  logic [9:0] southad,
    input  logic       e_vld,
    input  logic       w_vld,
    input  logic       n_vld,
    input  logic       s_vld,
    output logic [9:0] ead,
    output logic [9:0] wad,
    output logic [9:0] nad,
    output logic [9:0] sad,
    output logic       e_ovld,
    output logic       w_ovld,
    output logic       n_ovld,
    output logic       s_ovld,
    output logic [9:0] localad,
    output logic       local_vld,
    input  logic       local_rdy,
    output logic       eject_stall
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [9:0]    in_data [4];
    logic [3:0]    in_vld;
    logic [3:0]    match;
    logic [3:0]    cand;
    logic          win_found;
    logic [1:0]    win_idx;
    logic          pop;
    logic          eject;

    logic [9:0]    out_data_q [4];
    logic [9:0]    out_data_d [4];
    logic [3:0]    out_vld_q;
    logic [3:0]    out_vld_d;
    logic [9:0]    mem_q [DEPTH];
    logic [9:0]    mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    rr_ptr_q, rr_ptr_d;
    logic          eject_stall_q, eject_stall_d;

    assign in_data[0] = eastad;
    assign in_data[1] = westad;
    assign in_data[2] = northad;
    assign in_data[3] = southad;
    assign in_vld     = {s_vld, n_vld, w_vld, e_vld};

    assign ead    = out_data_q[0];
    assign wad    = out_data_q[1];
    assign nad    = out_data_q[2];
    assign sad    = out_data_q[3];
    assign e_ovld = out_vld_q[0];
    assign w_ovld = out_vld_q[1];
    assign n_ovld = out_vld_q[2];
    assign s_ovld = out_vld_q[3];

    assign local_vld   = (count_q != '0);
    assign localad     = mem_q[rd_ptr_q];
    assign eject_stall = eject_stall_q;

    // A channel matches when it is valid and addressed to this node's row and column
    always_comb begin
        match = 4'b0;
        for (int i = 0; i < 4; i++) begin
            match[i] = in_vld[i] && (in_data[i][5:3] == LOCAL_ROW)
                                 && (in_data[i][2:0] == LOCAL_COL);
        end
    end

    // Round-robin pick of the first candidate at or after rr_ptr; golden flits form the candidate set first when enabled
    always_comb begin
        logic [1:0] idx;
        cand      = match;
`ifdef GOLDEN_PRIORITY_EN
        for (int i = 0; i < 4; i++) begin
            if ((match & {in_data[3][9], in_data[2][9], in_data[1][9], in_data[0][9]}) != 4'b0) begin
                cand[i] = match[i] && in_data[i][9];
            end
        end
`endif
        win_found = 1'b0;
        win_idx   = 2'd0;
        idx       = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            idx = rr_ptr_q + 2'(k);
            if (cand[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    // Next-state for pass-through channels, FIFO, arbiter pointer and stall flag
    always_comb begin
        pop   = local_vld && local_rdy;
        eject = win_found && ((count_q < DEPTH_C) || pop);

        for (int i = 0; i < 4; i++) begin
            out_data_d[i] = in_data[i];
            out_vld_d[i]  = in_vld[i];
            if (eject && (win_idx == 2'(i))) begin
                out_data_d[i] = 10'b0;
                out_vld_d[i]  = 1'b0;
            end
        end

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (eject) begin
            mem_d[wr_ptr_q] = in_data[win_idx];
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({eject, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        rr_ptr_d      = eject ? (win_idx + 2'd1) : rr_ptr_q;
        eject_stall_d = (match != 4'b0) && !eject;
    end

    // State registers; synchronous reset discards flits in flight and FIFO contents
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                out_data_q[i] <= 10'b0;
            end
            for (int j = 0; j < DEPTH; j++) begin
                mem_q[j] <= 10'b0;
            end
            out_vld_q     <= 4'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            rr_ptr_q      <= 2'd0;
            eject_stall_q <= 1'b0;
        end else begin
            out_data_q    <= out_data_d;
            mem_q         <= mem_d;
            out_vld_q     <= out_vld_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            rr_ptr_q      <= rr_ptr_d;
            eject_stall_q <= eject_stall_d;
        end
    end

endmodule

// File: tb/tb_ejector.sv
// Directed testbench for ejector (node (4,4), DEPTH 4).
module tb_ejector;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [9:0] eastad, westad, northad, southad;
   logic       e_vld, w_vld, n_vld, s_vld;
   logic [9:0] ead, wad, nad, sad;
   logic       e_ovld, w_ovld, n_ovld, s_ovld;
   logic [9:0] localad;
   logic       local_vld;
   logic       local_rdy;
   logic       eject_stall;

   int total = 0;
   int bad   = 0;

   ejector #(.LOCAL_ROW(3'b100), .LOCAL_COL(3'b100), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .eastad(eastad), .westad(westad), .northad(northad), .southad(southad),
      .e_vld(e_vld), .w_vld(w_vld), .n_vld(n_vld), .s_vld(s_vld),
      .ead(ead), .wad(wad), .nad(nad), .sad(sad),
      .e_ovld(e_ovld), .w_ovld(w_ovld), .n_ovld(n_ovld), .s_ovld(s_ovld),
      .localad(localad), .local_vld(local_vld), .local_rdy(local_rdy),
      .eject_stall(eject_stall)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Drive one cycle of inputs (vld = {s,n,w,e}) and settle just after the edge
   task automatic applyStimulus(input logic [9:0] e, input logic [9:0] w,
                                input logic [9:0] n, input logic [9:0] s,
                                input logic [3:0] vld, input logic rdy,
                                input logic rstn);
      eastad = e; westad = w; northad = n; southad = s;
      {s_vld, n_vld, w_vld, e_vld} = vld;
      local_rdy = rdy;
      rst_n = rstn;
      @(posedge clk);
      #1;
   endtask

   // One comparison against a hand-computed value
   task automatic checkOutput(input string tag, input logic [9:0] observed,
                              input logic [9:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Directed sequence
   initial begin
      rst_n = 1'b0; local_rdy = 1'b0;
      eastad = '0; westad = '0; northad = '0; southad = '0;
      {s_vld, n_vld, w_vld, e_vld} = 4'b0;

      // Reset with matching traffic present for two cycles
      applyStimulus(10'h024, 10'h0E4, 10'h124, 10'h164, 4'hF, 1'b1, 1'b0);
      applyStimulus(10'h024, 10'h0E4, 10'h124, 10'h164, 4'hF, 1'b1, 1'b0);
      checkOutput("rst_ead", ead, 10'h000);
      checkOutput("rst_sad", sad, 10'h000);
      checkOutput("rst_vlds", {6'b0, s_ovld, n_ovld, w_ovld, e_ovld}, 10'h000);
      checkOutput("rst_local_vld", {9'b0, local_vld}, 10'h000);
      checkOutput("rst_stall", {9'b0, eject_stall}, 10'h000);

      // Contention: all four match for four cycles, winners 0,1,2,3
      applyStimulus(10'h024, 10'h0E4, 10'h124, 10'h164, 4'hF, 1'b1, 1'b1);
      checkOutput("rr0_e_vld", {9'b0, e_ovld}, 10'h000);
      checkOutput("rr0_ead", ead, 10'h000);
      checkOutput("rr0_wad", wad, 10'h0E4);
      checkOutput("rr0_s_vld", {9'b0, s_ovld}, 10'h001);
      checkOutput("rr0_local", localad, 10'h024);
      checkOutput("rr0_local_vld", {9'b0, local_vld}, 10'h001);
      applyStimulus(10'h024, 10'h0E4, 10'h124, 10'h164, 4'hF, 1'b1, 1'b1);
      checkOutput("rr1_w_vld", {9'b0, w_ovld}, 10'h000);
      checkOutput("rr1_ead", ead, 10'h024);
      checkOutput("rr1_local", localad, 10'h0E4);
      applyStimulus(10'h024, 10'h0E4, 10'h124, 10'h164, 4'hF, 1'b1, 1'b1);
      checkOutput("rr2_n_vld", {9'b0, n_ovld}, 10'h000);
      checkOutput("rr2_wad", wad, 10'h0E4);
      checkOutput("rr2_local", localad, 10'h124);
      applyStimulus(10'h024, 10'h0E4, 10'h124, 10'h164, 4'hF, 1'b1, 1'b1);
      checkOutput("rr3_s_vld", {9'b0, s_ovld}, 10'h000);
      checkOutput("rr3_nad", nad, 10'h124);
      checkOutput("rr3_local", localad, 10'h164);
      applyStimulus(10'h000, 10'h000, 10'h000, 10'h000, 4'h0, 1'b1, 1'b1);
      checkOutput("drain_local_vld", {9'b0, local_vld}, 10'h000);

      // Single eject on north, other channels non-matching
      applyStimulus(10'h011, 10'h0A2, 10'h124, 10'h1C3, 4'hF, 1'b0, 1'b1);
      checkOutput("single_n_vld", {9'b0, n_ovld}, 10'h000);
      checkOutput("single_nad", nad, 10'h000);
      checkOutput("single_ead", ead, 10'h011);
      checkOutput("single_wad", wad, 10'h0A2);
      checkOutput("single_sad", sad, 10'h1C3);
      checkOutput("single_vlds", {6'b0, s_ovld, n_ovld, w_ovld, e_ovld}, 10'h00B);
      checkOutput("single_local", localad, 10'h124);
      checkOutput("single_local_vld", {9'b0, local_vld}, 10'h001);
      checkOutput("single_stall", {9'b0, eject_stall}, 10'h000);
      applyStimulus(10'h000, 10'h000, 10'h000, 10'h000, 4'h0, 1'b1, 1'b1);

      // Full FIFO: four queued, fifth stalls and passes through
      applyStimulus(10'h024, 10'h000, 10'h000, 10'h000, 4'h1, 1'b0, 1'b1);
      applyStimulus(10'h064, 10'h000, 10'h000, 10'h000, 4'h1, 1'b0, 1'b1);
      applyStimulus(10'h0A4, 10'h000, 10'h000, 10'h000, 4'h1, 1'b0, 1'b1);
      applyStimulus(10'h0E4, 10'h000, 10'h000, 10'h000, 4'h1, 1'b0, 1'b1);
      checkOutput("full4_stall", {9'b0, eject_stall}, 10'h000);
      checkOutput("full4_e_vld", {9'b0, e_ovld}, 10'h000);
      checkOutput("full4_local", localad, 10'h024);
      applyStimulus(10'h224, 10'h000, 10'h000, 10'h000, 4'h1, 1'b0, 1'b1);
      checkOutput("full5_stall", {9'b0, eject_stall}, 10'h001);
      checkOutput("full5_ead", ead, 10'h224);
      checkOutput("full5_e_vld", {9'b0, e_ovld}, 10'h001);
      checkOutput("full5_local", localad, 10'h024);
      // Pop and push together at full
      applyStimulus(10'h000, 10'h1A4, 10'h000, 10'h000, 4'h2, 1'b1, 1'b1);
      checkOutput("fullpp_stall", {9'b0, eject_stall}, 10'h000);
      checkOutput("fullpp_w_vld", {9'b0, w_ovld}, 10'h000);
      checkOutput("fullpp_local", localad, 10'h064);
      applyStimulus(10'h000, 10'h000, 10'h000, 10'h000, 4'h0, 1'b1, 1'b1);
      checkOutput("drain1", localad, 10'h0A4);
      applyStimulus(10'h000, 10'h000, 10'h000, 10'h000, 4'h0, 1'b1, 1'b1);
      checkOutput("drain2", localad, 10'h0E4);
      applyStimulus(10'h000, 10'h000, 10'h000, 10'h000, 4'h0, 1'b1, 1'b1);
      checkOutput("drain3", localad, 10'h1A4);
      checkOutput("drain3_vld", {9'b0, local_vld}, 10'h001);
      applyStimulus(10'h000, 10'h000, 10'h000, 10'h000, 4'h0, 1'b1, 1'b1);
      checkOutput("drain4_vld", {9'b0, local_vld}, 10'h000);

      // Mid-operation reset with three flits queued
      applyStimulus(10'h024, 10'h000, 10'h000, 10'h000, 4'h1, 1'b0, 1'b1);
      applyStimulus(10'h064, 10'h000, 10'h000, 10'h000, 4'h1, 1'b0, 1'b1);
      applyStimulus(10'h0A4, 10'h000, 10'h000, 10'h000, 4'h1, 1'b0, 1'b1);
      checkOutput("pre_rst_vld", {9'b0, local_vld}, 10'h001);
      applyStimulus(10'h024, 10'h0E4, 10'h124, 10'h164, 4'hF, 1'b0, 1'b0);
      checkOutput("midrst_local_vld", {9'b0, local_vld}, 10'h000);
      checkOutput("midrst_vlds", {6'b0, s_ovld, n_ovld, w_ovld, e_ovld}, 10'h000);
      checkOutput("midrst_wad", wad, 10'h000);

      // Golden arbitration from rr_ptr=0: east non-golden vs south golden
      applyStimulus(10'h024, 10'h000, 10'h000, 10'h3E4, 4'h9, 1'b0, 1'b1);
      checkOutput("gold_local_vld", {9'b0, local_vld}, 10'h001);
      checkOutput("gold_stall", {9'b0, eject_stall}, 10'h000);
`ifdef GOLDEN_PRIORITY_EN
      checkOutput("gold_local", localad, 10'h3E4);
      checkOutput("gold_ead", ead, 10'h024);
      checkOutput("gold_vlds", {6'b0, s_ovld, n_ovld, w_ovld, e_ovld}, 10'h001);
`else
      checkOutput("gold_local", localad, 10'h024);
      checkOutput("gold_sad", sad, 10'h3E4);
      checkOutput("gold_vlds", {6'b0, s_ovld, n_ovld, w_ovld, e_ovld}, 10'h008);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
